// File: rtl/simd_alu_pkg.sv
// Shared types and the per-lane compute function for the SIMD execute-stage ALU.
// lane_op works on a zero-padded 64-bit container so one function serves every lane width.
package simd_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLT    = 4'd5,
        OP_SLTU   = 4'd6,
        OP_SLL    = 4'd7,
        OP_SRL    = 4'd8,
        OP_SRA    = 4'd9,
        OP_REDSUM = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RED  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int MAXW = 64;
    typedef logic [MAXW-1:0] word_t;

    // lw must be a power of two; the shift amount is the low log2(lw) bits of b.
    function automatic word_t lane_op(input alu_op_e op, input word_t a, input word_t b,
                                      input int lw);
        word_t      mask;
        word_t      am;
        word_t      bm;
        word_t      sa;
        word_t      sb;
        word_t      r;
        logic [6:0] sh;
        mask = (lw >= MAXW) ? '1 : ((word_t'(1) << lw) - word_t'(1));
        am   = a & mask;
        bm   = b & mask;
        sa   = word_t'($signed(am << (MAXW - lw)) >>> (MAXW - lw));
        sb   = word_t'($signed(bm << (MAXW - lw)) >>> (MAXW - lw));
        sh   = bm[6:0] & 7'(lw - 1);
        case (op)
            OP_ADD:  r = am + bm;
            OP_SUB:  r = am - bm;
            OP_AND:  r = am & bm;
            OP_OR:   r = am | bm;
            OP_XOR:  r = am ^ bm;
            OP_SLT:  r = ($signed(sa) < $signed(sb)) ? word_t'(1) : '0;
            OP_SLTU: r = (am < bm) ? word_t'(1) : '0;
            OP_SLL:  r = am << sh;
            OP_SRL:  r = am >> sh;
            OP_SRA:  r = word_t'($signed(sa) >>> sh);
            default: r = '0;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/simd_alu_lane.sv
// One combinational ALU lane of width W; used both per SIMD lane and as the full-width scalar ALU.
module simd_alu_lane
    import simd_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  alu_op_e      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = W'(lane_op(op, word_t'(a), word_t'(b), W));

endmodule

// File: rtl/simd_alu_unit.sv
// Execute-stage ALU with scalar/packed-SIMD modes, a multi-cycle lane reduction (REDSUM)
// and a valid/ready registered output stage.
module simd_alu_unit
    import simd_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alu_src,
    input  logic             simd_en,
    input  logic [3:0]       alu_control,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  write_data,
    output logic             zero,
    output logic [LANES-1:0] lane_zero
);

    localparam int LW = XLEN / LANES;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    state_e            state_reg, state_next;
    logic [XLEN-1:0]   result_reg;
    logic [XLEN-1:0]   write_data_reg;
    logic [XLEN-1:0]   acc_reg;
    logic [XLEN-1:0]   a_lat_reg;
    logic [CW-1:0]     cnt_reg;
    logic              red_done_reg;

    alu_op_e           op_in;
    logic [XLEN-1:0]   operand_b;
    logic [XLEN-1:0]   scalar_res;
    logic [XLEN-1:0]   simd_res;
    logic [XLEN-1:0]   comp_res;
    logic              accept;
    logic              is_redsum;
    logic [LW-1:0]     cur_lane;
    logic [XLEN-1:0]   lane_sext;

    assign op_in     = alu_op_e'(alu_control);
    assign operand_b = alu_src ? imm_ext : rs2_data;
    assign accept    = in_valid && in_ready;
    assign is_redsum = (op_in == OP_REDSUM);

    simd_alu_lane #(.W(XLEN)) u_scalar (
        .op (op_in),
        .a  (src_a),
        .b  (operand_b),
        .y  (scalar_res)
    );

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            simd_alu_lane #(.W(LW)) u_lane (
                .op (op_in),
                .a  (src_a[gi*LW +: LW]),
                .b  (operand_b[gi*LW +: LW]),
                .y  (simd_res[gi*LW +: LW])
            );
            assign lane_zero[gi] = (result_reg[gi*LW +: LW] == '0);
        end
    endgenerate

    assign comp_res  = simd_en ? simd_res : scalar_res;
    assign cur_lane  = a_lat_reg[cnt_reg*LW +: LW];
    assign lane_sext = {{(XLEN-LW){cur_lane[LW-1]}}, cur_lane};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = is_redsum ? RED : HOLD;
                end
            end
            RED: begin
                if (red_done_reg) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = is_redsum ? RED : HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready = 1'b1;
            HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // RED spends one extra cycle after the last lane so the final sum is copied
    // into result_reg before HOLD is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg     <= '0;
            write_data_reg <= '0;
            acc_reg        <= '0;
            a_lat_reg      <= '0;
            cnt_reg        <= '0;
            red_done_reg   <= 1'b0;
        end else begin
            if (accept) begin
                write_data_reg <= rs2_data;
                if (is_redsum) begin
                    acc_reg      <= '0;
                    cnt_reg      <= '0;
                    red_done_reg <= 1'b0;
                    a_lat_reg    <= src_a;
                end else begin
                    result_reg <= comp_res;
                end
            end
            if (state_reg == RED) begin
                if (red_done_reg) begin
                    result_reg <= acc_reg;
                end else begin
                    acc_reg <= acc_reg + lane_sext;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(LANES - 1)) begin
                        red_done_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign alu_result = result_reg;
    assign write_data = write_data_reg;
    assign zero       = (result_reg == '0);

endmodule

// File: tb/tb_simd_alu_unit.sv
// Directed-vector bench for simd_alu_unit (XLEN=32, LANES=4) with hand-computed expectations.
module tb_simd_alu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        alu_src;
    logic        simd_en;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] rs2_data;
    logic [31:0] imm_ext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        zero;
    logic [3:0]  lane_zero;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    simd_alu_unit #(.XLEN(32), .LANES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_src     (alu_src),
        .simd_en     (simd_en),
        .alu_control (alu_control),
        .src_a       (src_a),
        .rs2_data    (rs2_data),
        .imm_ext     (imm_ext),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .write_data  (write_data),
        .zero        (zero),
        .lane_zero   (lane_zero)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic simd, input logic src,
                            input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm);
        in_valid    = 1'b1;
        alu_control = op;
        simd_en     = simd;
        alu_src     = src;
        src_a       = a;
        rs2_data    = r2;
        imm_ext     = imm;
    endtask

    logic [31:0] q_a   [4] = '{32'd1, 32'd10, 32'hFFFF_FFFF, 32'h0000_0100};
    logic [31:0] q_b   [4] = '{32'd2, 32'd20, 32'd1,         32'h0000_0200};
    logic [31:0] q_exp [4] = '{32'd3, 32'd30, 32'd0,         32'h0000_0300};

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        alu_src     = 1'b0;
        simd_en     = 1'b0;
        alu_control = 4'd0;
        src_a       = '0;
        rs2_data    = '0;
        imm_ext     = '0;
        out_ready   = 1'b1;
        step();
        step();
        reset = 1'b0;

        check_value("reset out_valid", 32'(out_valid), 32'd0);
        check_value("reset in_ready", 32'(in_ready), 32'd1);
        check_value("reset alu_result", alu_result, 32'd0);
        check_value("reset write_data", write_data, 32'd0);
        check_value("reset zero", 32'(zero), 32'd1);
        check_value("reset lane_zero", 32'(lane_zero), 32'hF);

        // Scalar ADD
        drive_op(4'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
        step();
        in_valid = 1'b0;
        check_value("add out_valid", 32'(out_valid), 32'd1);
        check_value("add result", alu_result, 32'd12);
        check_value("add zero", 32'(zero), 32'd0);
        check_value("add write_data", write_data, 32'd7);
        check_value("add in_ready", 32'(in_ready), 32'd1);
        step();
        check_value("add drain out_valid", 32'(out_valid), 32'd0);

        // SIMD ADD, no inter-lane carry
        drive_op(4'd0, 1'b1, 1'b0, 32'h01FF_7F80, 32'h0101_0180, 32'd0);
        step();
        in_valid = 1'b0;
        check_value("simd add result", alu_result, 32'h0200_8000);
        check_value("simd add lane_zero", 32'(lane_zero), 32'h5);
        check_value("simd add zero", 32'(zero), 32'd0);
        step();

        // Immediate path SUB
        drive_op(4'd1, 1'b0, 1'b1, 32'd3, 32'hDEAD_BEEF, 32'd5);
        step();
        in_valid = 1'b0;
        check_value("imm sub result", alu_result, 32'hFFFF_FFFE);
        check_value("imm sub write_data", write_data, 32'hDEAD_BEEF);
        step();

        // SIMD SLT and scalar SLL (shift amount uses only low 5 bits)
        drive_op(4'd5, 1'b1, 1'b0, 32'h8001_FF00, 32'h0002_0100, 32'd0);
        step();
        check_value("simd slt result", alu_result, 32'h0101_0100);
        drive_op(4'd7, 1'b0, 1'b0, 32'd1, 32'h0000_0021, 32'd0);
        step();
        in_valid = 1'b0;
        check_value("sll result", alu_result, 32'd2);
        step();

        // REDSUM
        drive_op(4'd10, 1'b0, 1'b0, 32'h80FF_0102, 32'h0000_1234, 32'd0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_value($sformatf("redsum busy%0d in_ready", k), 32'(in_ready), 32'd0);
            check_value($sformatf("redsum busy%0d out_valid", k), 32'(out_valid), 32'd0);
            step();
        end
        check_value("redsum edge4 out_valid", 32'(out_valid), 32'd0);
        step();
        check_value("redsum edge5 out_valid", 32'(out_valid), 32'd1);
        check_value("redsum result", alu_result, 32'hFFFF_FF82);
        check_value("redsum write_data", write_data, 32'h0000_1234);
        step();

        // Backpressure with SIMD SRA, then four queued ADDs
        out_ready = 1'b0;
        drive_op(4'd9, 1'b1, 1'b0, 32'h80F0_4010, 32'h0101_0101, 32'd0);
        step();
        check_value("sra result", alu_result, 32'hC0F8_2008);
        drive_op(4'd0, 1'b0, 1'b0, q_a[0], q_b[0], 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_value($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            check_value($sformatf("stall%0d result", k), alu_result, 32'hC0F8_2008);
            check_value($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            check_value($sformatf("stall%0d write_data", k), write_data, 32'h0101_0101);
        end
        out_ready = 1'b1;
        #1;
        check_value("release in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive_op(4'd0, 1'b0, 1'b0, q_a[i], q_b[i], 32'd0);
            step();
            check_value($sformatf("queued add%0d out_valid", i), 32'(out_valid), 32'd1);
            check_value($sformatf("queued add%0d result", i), alu_result, q_exp[i]);
            check_value($sformatf("queued add%0d zero", i), 32'(zero), 32'(q_exp[i] == 32'd0));
        end
        in_valid = 1'b0;
        step();
        check_value("queue drain out_valid", 32'(out_valid), 32'd0);

        // Reset during the second RED cycle
        drive_op(4'd10, 1'b0, 1'b0, 32'h0101_0101, 32'h0000_00AA, 32'd0);
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("midred reset out_valid", 32'(out_valid), 32'd0);
        check_value("midred reset in_ready", 32'(in_ready), 32'd1);
        check_value("midred reset result", alu_result, 32'd0);
        check_value("midred reset zero", 32'(zero), 32'd1);
        check_value("midred reset lane_zero", 32'(lane_zero), 32'hF);
        drive_op(4'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
        check_value("post reset add out_valid", 32'(out_valid), 32'd1);
        check_value("post reset add result", alu_result, 32'd2);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
